// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: register-file write port merging ALU results with buffered load returns,
// plus a pending-load scoreboard for decode RAW hazard stalls.
module wb_writeback_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [WIDTH-1:0]           alu_data,
    input  logic                       ld_issue,
    input  logic [AW-1:0]              ld_issue_rd,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_rd,
    input  logic [WIDTH-1:0]           ld_data,
    input  logic [AW-1:0]              rs1addr,
    input  logic [AW-1:0]              rs2addr,
    output logic                       regwr,
    output logic [AW-1:0]              rdaddr,
    output logic [WIDTH-1:0]           win,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       ovf_err,
    output logic                       waw_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int NR = 1 << AW;

    logic [AW-1:0]    rd_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [NR-1:0]    pending, pend_nxt;
    logic             alu_sel, pop, byp, push, full, do_push, waw;
    logic [AW-1:0]    sel_rd;
    logic [WIDTH-1:0] sel_data;

    // ALU has priority, then FIFO head, then a direct load bypass when the FIFO is empty
    always_comb begin
        alu_sel  = alu_valid && alu_rd != '0;
        pop      = !alu_sel && fifo_level != '0;
        byp      = !alu_sel && fifo_level == '0 && ld_valid && ld_rd != '0;
        push     = ld_valid && ld_rd != '0 && !byp;
        full     = fifo_level == LW'(DEPTH);
        do_push  = push && (!full || pop);
        sel_rd   = alu_sel ? alu_rd : pop ? rd_mem[head] : ld_rd;
        sel_data = alu_sel ? alu_data : pop ? data_mem[head] : ld_data;
        waw      = (ld_issue && ld_issue_rd != '0 && pending[ld_issue_rd]) ||
                   (alu_sel && pending[alu_rd]);
    end

    // clear on load writeback first so a same-cycle reissue keeps the bit set
    always_comb begin
        pend_nxt = pending;
        if (pop || byp)
            pend_nxt[sel_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != '0)
            pend_nxt[ld_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwr      <= 1'b0;
            rdaddr     <= '0;
            win        <= '0;
            head       <= '0;
            tail       <= '0;
            fifo_level <= '0;
            pending    <= '0;
            ovf_err    <= 1'b0;
            waw_err    <= 1'b0;
        end else begin
            regwr      <= alu_sel || pop || byp;
            rdaddr     <= (alu_sel || pop || byp) ? sel_rd : rdaddr;
            win        <= (alu_sel || pop || byp) ? sel_data : win;
            head       <= head + PW'(pop);
            tail       <= tail + PW'(do_push);
            fifo_level <= fifo_level + LW'(do_push) - LW'(pop);
            pending    <= pend_nxt;
            ovf_err    <= ovf_err || (push && full && !pop);
            waw_err    <= waw_err || waw;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[tail]   <= ld_rd;
            data_mem[tail] <= ld_data;
        end
    end

    assign rs1_busy = pending[rs1addr];
    assign rs2_busy = pending[rs2addr];
endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb_wb_writeback_unit: scoreboard bench; a queue-based reference model predicts register
// writes, occupancy, scoreboard and error flags for directed and random traffic.
module tb_wb_writeback_unit;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, ld_issue, ld_valid;
    logic [AW-1:0]    alu_rd, ld_issue_rd, ld_rd, rs1addr, rs2addr;
    logic [WIDTH-1:0] alu_data, ld_data;
    logic             regwr, rs1_busy, rs2_busy, ovf_err, waw_err;
    logic [AW-1:0]    rdaddr;
    logic [WIDTH-1:0] win;
    logic [$clog2(DEPTH):0] fifo_level;

    wb_writeback_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .rs1addr(rs1addr), .rs2addr(rs2addr),
        .regwr(regwr), .rdaddr(rdaddr), .win(win),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .fifo_level(fifo_level), .ovf_err(ovf_err), .waw_err(waw_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t       mq[$];
    wr_t       expq[$];
    bit [31:0] mpend;
    bit        movf, mwaw, mregwr;
    int        n_chk = 0;
    int        n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every emitted write must match the oldest predicted write
    always @(negedge clk) begin
        if (regwr) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected none", rdaddr, win);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("wr_rd", 64'(rdaddr), 64'(e.rd));
                chk("wr_data", 64'(win), 64'(e.data));
            end
        end
    end

    task automatic model_step();
        bit  alu_w, ld_ok, taken, has, is_ld;
        wr_t w, l;
        alu_w = alu_valid && alu_rd != 0;
        ld_ok = ld_valid && ld_rd != 0;
        taken = 0; has = 0; is_ld = 0;
        l.rd = ld_rd; l.data = ld_data;
        if (ld_issue && ld_issue_rd != 0 && mpend[ld_issue_rd]) mwaw = 1;
        if (alu_w && mpend[alu_rd]) mwaw = 1;
        if (alu_w) begin
            w.rd = alu_rd; w.data = alu_data; has = 1;
        end else if (mq.size() > 0) begin
            w = mq.pop_front(); has = 1; is_ld = 1;
        end else if (ld_ok) begin
            w = l; has = 1; is_ld = 1; taken = 1;
        end
        if (ld_ok && !taken) begin
            if (mq.size() < DEPTH) mq.push_back(l);
            else movf = 1;
        end
        if (is_ld) mpend[w.rd] = 0;
        if (ld_issue && ld_issue_rd != 0) mpend[ld_issue_rd] = 1;
        if (has) expq.push_back(w);
        mregwr = has;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("regwr", 64'(regwr), 64'(mregwr));
        chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
        chk("rs1_busy", 64'(rs1_busy), 64'(rs1addr != 0 && mpend[rs1addr]));
        chk("rs2_busy", 64'(rs2_busy), 64'(rs2addr != 0 && mpend[rs2addr]));
        chk("ovf_err", 64'(ovf_err), 64'(movf));
        chk("waw_err", 64'(waw_err), 64'(mwaw));
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
    endtask

    // async reset asserted between edges; outputs must clear without a clock
    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_regwr", 64'(regwr), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_busy1", 64'(rs1_busy), 64'(0));
        chk("rst_busy2", 64'(rs2_busy), 64'(0));
        chk("rst_ovf", 64'(ovf_err), 64'(0));
        chk("rst_waw", 64'(waw_err), 64'(0));
        mq.delete(); expq.delete();
        mpend = 0; movf = 0; mwaw = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        idle();
        rs1addr = 0; rs2addr = 0;
        mpend = 0; movf = 0; mwaw = 0;
        rst = 1;
        #2;
        chk("reset_regwr", 64'(regwr), 64'(0));
        chk("reset_rdaddr", 64'(rdaddr), 64'(0));
        chk("reset_win", 64'(win), 64'(0));
        chk("reset_level", 64'(fifo_level), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cycle();
        chk("alu_rdaddr", 64'(rdaddr), 64'(5));
        chk("alu_win", 64'(win), 64'hDEADBEEF);
        alu_rd = 0; alu_data = 32'h1;
        cycle();
        chk("alu_x0", 64'(regwr), 64'(0));
        idle();

        // load bypass and scoreboard
        ld_issue = 1; ld_issue_rd = 7; rs1addr = 7;
        cycle();
        chk("busy7", 64'(rs1_busy), 64'(1));
        idle();
        cycle();
        ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
        cycle();
        chk("byp_win", 64'(win), 64'h1234);
        idle();
        cycle();
        chk("busy7_clear", 64'(rs1_busy), 64'(0));

        // ALU/load collision
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA;
        ld_valid = 1; ld_rd = 4; ld_data = 32'hB;
        cycle();
        chk("coll_level1", 64'(fifo_level), 64'(1));
        idle();
        cycle();
        chk("coll_level0", 64'(fifo_level), 64'(0));
        chk("coll_win", 64'(win), 64'hB);

        // overflow: five loads under continuous ALU traffic
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 5'(1 + i); alu_data = 32'(100 + i);
            ld_valid = (i < 5); ld_rd = 5'(10 + i); ld_data = 32'(32'hC0 + i);
            cycle();
        end
        chk("full_level", 64'(fifo_level), 64'(4));
        chk("full_ovf", 64'(ovf_err), 64'(1));
        idle();
        repeat (5) cycle();

        // push+pop while full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'(i);
            ld_valid = 1; ld_rd = 5'(12 + i); ld_data = 32'(32'hD0 + i);
            cycle();
        end
        idle();
        ld_valid = 1; ld_rd = 17; ld_data = 32'hD4;
        cycle();
        chk("pp_level", 64'(fifo_level), 64'(4));
        chk("pp_ovf", 64'(ovf_err), 64'(0));
        idle();
        repeat (5) cycle();

        // WAW then reset mid-drain
        ld_issue = 1; ld_issue_rd = 9; rs1addr = 9;
        cycle();
        cycle();
        chk("waw_set", 64'(waw_err), 64'(1));
        idle();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 2; alu_data = 32'(i);
            ld_valid = 1; ld_rd = 5'(24 + i); ld_data = 32'(i);
            cycle();
        end
        idle();
        cycle();
        do_reset();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_rd = 5'($urandom_range(0, 7));
            alu_data = $urandom;
            ld_issue = ($urandom_range(0, 4) == 0);
            ld_issue_rd = 5'($urandom_range(0, 7));
            ld_valid = ($urandom_range(0, 2) == 0);
            ld_rd = 5'($urandom_range(0, 7));
            ld_data = $urandom;
            rs1addr = 5'($urandom_range(0, 7));
            rs2addr = 5'($urandom_range(0, 7));
            cycle();
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        idle();
        repeat (8) cycle();
        @(posedge clk);
        #1;
        chk("drain_empty", 64'(expq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
